// File: rtl/axi_arbiter_pkg.sv
// Shared sizing and FSM encoding for the AXI-Stream packet arbiter.
package axi_arbiter_pkg;
  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int IDX_W  = $clog2(N_CH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/axis_arbiter_if.sv
// Stream bundle plus the side-band carrying the current grant index.
interface IAxiStream
  import axi_arbiter_pkg::*;
(
  input logic clk,
  input logic nrst
);
  logic              t_valid;
  logic              t_last;
  logic [DATA_W-1:0] t_data;
  logic [ID_W-1:0]   t_id;
  logic              t_ready;

  modport master (output t_valid, t_last, t_data, t_id, input t_ready);
  modport slave  (input t_valid, t_last, t_data, t_id, output t_ready);

  // a beat that was offered but not taken must still be offered next cycle
  // (nrst carries the active-high reset of the arbiter)
  a_hold: assert property (@(posedge clk) disable iff (nrst)
    (t_valid && !t_ready) |=> t_valid);
endinterface

interface AxiAddition
  import axi_arbiter_pkg::*;
(
  input logic clk
);
  logic [IDX_W-1:0] idx_channel;

  // grant index is a register output and must always be defined
  a_known: assert property (@(posedge clk) !$isunknown(idx_channel));
endinterface

// File: rtl/rr_select.sv
// Rotating first-set search: first request at ptr, ptr+1, ... (mod N_CH).
// Index arithmetic wraps in IDX_W bits, so N_CH must be a power of two.
module rr_select
  import axi_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);
  logic [IDX_W-1:0] w_cand;

  // scan from the farthest offset to the nearest so the nearest hit wins
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_cand  = i_ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_cand = i_ptr + IDX_W'(i);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end
endmodule

// File: rtl/axis_arbiter.sv
// Packet-granular round-robin merge of four AXI-Stream inputs onto one output.
// A grant is held until the t_last beat handshakes; one idle cycle re-arbitrates.
module axis_arbiter
  import axi_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  IAxiStream.slave         in_0,
  IAxiStream.slave         in_1,
  IAxiStream.slave         in_2,
  IAxiStream.slave         in_3,
  IAxiStream.master        out,
  output logic [IDX_W-1:0] idx_channel
);
  state_t                      r_state, w_state_nxt;
  logic [IDX_W-1:0]            r_grant, w_grant_nxt;
  logic [IDX_W-1:0]            r_ptr, w_ptr_nxt;
  logic [N_CH-1:0]             w_valid, w_last, w_rdy;
  logic [N_CH-1:0][DATA_W-1:0] w_data;
  logic [N_CH-1:0][ID_W-1:0]   w_id;
  logic                        w_found;
  logic [IDX_W-1:0]            w_sel;
  logic                        w_last_hs;

  assign w_valid = {in_3.t_valid, in_2.t_valid, in_1.t_valid, in_0.t_valid};
  assign w_last  = {in_3.t_last,  in_2.t_last,  in_1.t_last,  in_0.t_last};
  assign w_data  = {in_3.t_data,  in_2.t_data,  in_1.t_data,  in_0.t_data};
  assign w_id    = {in_3.t_id,    in_2.t_id,    in_1.t_id,    in_0.t_id};

  assign in_0.t_ready = w_rdy[0];
  assign in_1.t_ready = w_rdy[1];
  assign in_2.t_ready = w_rdy[2];
  assign in_3.t_ready = w_rdy[3];

  assign w_last_hs = out.t_valid & out.t_ready & out.t_last;

  rr_select u_sel (
    .i_req   (w_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_sel)
  );

  // grant index is also published on the side-band bundle
  AxiAddition u_add (.clk(clk));
  assign u_add.idx_channel = r_grant;
  assign idx_channel       = u_add.idx_channel;

  // state, grant and rotation pointer; reset abandons any packet in flight
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // grant on any request when idle; release only on the t_last handshake
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_sel;
        end
      end
      BUSY: begin
        if (w_last_hs) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_grant + IDX_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // steer the granted channel through; nothing moves while idle
  always_comb begin
    out.t_valid = 1'b0;
    out.t_last  = w_last[r_grant];
    out.t_data  = w_data[r_grant];
    out.t_id    = w_id[r_grant];
    w_rdy       = '0;
    if (r_state == BUSY) begin
      out.t_valid    = w_valid[r_grant];
      w_rdy[r_grant] = out.t_ready;
    end
  end
endmodule

// File: tb/tb_axis_arbiter.sv
// Randomized bench: per-channel packet generators, a cycle-level behavioural
// arbiter model and per-channel expected-beat queues.
module tb_axis_arbiter;
  import axi_arbiter_pkg::*;

  typedef logic [DATA_W+ID_W:0] beat_t;   // {last, id, data}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IDX_W-1:0] idx_channel;
  always #5 clk = ~clk;

  IAxiStream s0 (.clk(clk), .nrst(rst));
  IAxiStream s1 (.clk(clk), .nrst(rst));
  IAxiStream s2 (.clk(clk), .nrst(rst));
  IAxiStream s3 (.clk(clk), .nrst(rst));
  IAxiStream so (.clk(clk), .nrst(rst));

  axis_arbiter dut (
    .clk         (clk),
    .reset_n     (rst),
    .in_0        (s0),
    .in_1        (s1),
    .in_2        (s2),
    .in_3        (s3),
    .out         (so),
    .idx_channel (idx_channel)
  );

  logic [N_CH-1:0]   src_valid, src_last, rdy;
  logic [DATA_W-1:0] src_data [N_CH];
  logic [ID_W-1:0]   src_id   [N_CH];
  logic              out_ready;

  assign s0.t_valid = src_valid[0]; assign s0.t_last = src_last[0];
  assign s0.t_data  = src_data[0];  assign s0.t_id   = src_id[0];
  assign s1.t_valid = src_valid[1]; assign s1.t_last = src_last[1];
  assign s1.t_data  = src_data[1];  assign s1.t_id   = src_id[1];
  assign s2.t_valid = src_valid[2]; assign s2.t_last = src_last[2];
  assign s2.t_data  = src_data[2];  assign s2.t_id   = src_id[2];
  assign s3.t_valid = src_valid[3]; assign s3.t_last = src_last[3];
  assign s3.t_data  = src_data[3];  assign s3.t_id   = src_id[3];
  assign rdy = {s3.t_ready, s2.t_ready, s1.t_ready, s0.t_ready};
  assign so.t_ready = out_ready;

  // generators
  int    pkts_left [N_CH];
  int    idle_wait [N_CH];
  int    beat      [N_CH];
  bit    active    [N_CH];
  beat_t pkt       [N_CH][$];
  beat_t exp_q     [N_CH][$];
  int    cfg_min_len, cfg_max_len, cfg_gap_pct, cfg_idle_max, cfg_rdy_pct;
  logic [N_CH-1:0] hs_prev;

  // reference arbiter
  bit              m_busy, m_first;
  int              m_owner, m_next;
  logic [IDX_W-1:0] m_idx;

  // statistics
  int cyc, n_hs, first_hs, last_hs, n_pkts;
  int idx_log[$];
  logic [N_CH-1:0] ready_seen;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic new_packet(input int k);
    int    len;
    beat_t w;
    len = $urandom_range(cfg_max_len, cfg_min_len);
    for (int b = 0; b < len; b++) begin
      w = {1'(b == len - 1), ID_W'($urandom), DATA_W'($urandom)};
      pkt[k].push_back(w);
      exp_q[k].push_back(w);
    end
    beat[k]   = 0;
    active[k] = 1'b1;
  endtask

  // runs just after the rising edge: advance on accepted beats, offer the next
  task automatic drive_sources();
    for (int k = 0; k < N_CH; k++) begin
      if (hs_prev[k] && active[k]) begin
        beat[k]++;
        if (beat[k] == pkt[k].size()) begin
          active[k] = 1'b0;
          pkt[k].delete();
          pkts_left[k]--;
          idle_wait[k] = $urandom_range(cfg_idle_max, 0);
        end
      end
      if (!active[k] && pkts_left[k] > 0) begin
        if (idle_wait[k] > 0) idle_wait[k]--;
        else new_packet(k);
      end
      if (active[k]) begin
        if (!(src_valid[k] && !hs_prev[k]))
          src_valid[k] = ($urandom_range(99, 0) >= cfg_gap_pct);
        {src_last[k], src_id[k], src_data[k]} = pkt[k][beat[k]];
      end else begin
        src_valid[k] = 1'b0;
        src_last[k]  = 1'b0;
        src_id[k]    = '0;
        src_data[k]  = '0;
      end
    end
    out_ready = ($urandom_range(99, 0) < cfg_rdy_pct);
  endtask

  // runs on the falling edge: compare outputs, then step the reference
  task automatic sample_check();
    logic [N_CH-1:0] exp_rdy;
    beat_t got, e;
    int c;
    bit found;
    cyc++;
    hs_prev    = src_valid & rdy;
    ready_seen = ready_seen | rdy;
    if (!m_busy) begin
      chk("idle_valid", so.t_valid, 0);
      chk("idle_ready", rdy, 0);
      chk("idle_idx", idx_channel, m_idx);
      found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        c = (m_next + i) % N_CH;
        if (!found && src_valid[c]) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_first = 1'b1;
        m_idx   = IDX_W'(m_owner);
      end
    end else begin
      chk("grant_idx", idx_channel, m_owner);
      chk("out_valid", so.t_valid, src_valid[m_owner]);
      exp_rdy = '0;
      exp_rdy[m_owner] = out_ready;
      chk("in_ready", rdy, exp_rdy);
      if (so.t_valid && out_ready) begin
        got = {so.t_last, so.t_id, so.t_data};
        chk("sb_avail", exp_q[m_owner].size() != 0, 1);
        if (exp_q[m_owner].size() != 0) begin
          e = exp_q[m_owner].pop_front();
          chk("beat", got, e);
          if (n_hs == 0) first_hs = cyc;
          last_hs = cyc;
          n_hs++;
          if (m_first) begin
            idx_log.push_back(int'(idx_channel));
            m_first = 1'b0;
          end
          if (e[DATA_W+ID_W]) begin
            m_busy = 1'b0;
            m_next = (m_owner + 1) % N_CH;
            n_pkts++;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive_sources();
    @(negedge clk);
    sample_check();
  endtask

  task automatic clear_tb();
    for (int k = 0; k < N_CH; k++) begin
      pkts_left[k] = 0; idle_wait[k] = 0; beat[k] = 0; active[k] = 1'b0;
      pkt[k].delete(); exp_q[k].delete();
      src_data[k] = '0; src_id[k] = '0;
    end
    src_valid = '0; src_last = '0; hs_prev = '0;
    m_busy = 1'b0; m_first = 1'b0; m_next = 0; m_owner = 0; m_idx = '0;
  endtask

  task automatic set_cfg(input int mn, input int mx, input int gap, input int idl, input int rp);
    cfg_min_len = mn; cfg_max_len = mx; cfg_gap_pct = gap; cfg_idle_max = idl; cfg_rdy_pct = rp;
    n_hs = 0; first_hs = 0; last_hs = 0; n_pkts = 0; ready_seen = '0;
    idx_log.delete();
  endtask

  function automatic bit all_idle();
    bit r = !m_busy;
    for (int k = 0; k < N_CH; k++)
      if (pkts_left[k] != 0 || exp_q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic run(input string tag, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget && (n_chk - n_pass) < 100) begin
      step();
      n++;
      done = all_idle();
    end
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    int w;
    clear_tb();
    out_ready = 1'b0;
    set_cfg(1, 1, 0, 0, 100);
    rst = 1'b1;
    repeat (3) step();
    chk("rst_idx", idx_channel, 0);
    chk("rst_valid", so.t_valid, 0);
    chk("rst_ready", rdy, 0);
    rst = 1'b0;

    // all four channels, one 3-beat packet each
    set_cfg(3, 3, 0, 0, 100);
    for (int k = 0; k < N_CH; k++) pkts_left[k] = 1;
    run("t26", 200);
    chk("t26_beats", n_hs, 12);
    chk("t26_bubbles", (last_hs - first_hs + 1) - n_hs, 3);
    chk("t26_npkt", idx_log.size(), 4);
    for (int i = 0; i < idx_log.size() && i < 4; i++) chk("t26_order", idx_log[i], i);

    // ch2 alone, five packets back to back
    set_cfg(3, 3, 0, 0, 100);
    pkts_left[2] = 5;
    run("t27", 200);
    chk("t27_beats", n_hs, 15);
    chk("t27_bubbles", (last_hs - first_hs + 1) - n_hs, 4);
    chk("t27_npkt", idx_log.size(), 5);
    for (int i = 0; i < idx_log.size(); i++) chk("t27_grant", idx_log[i], 2);
    chk("t27_other_rdy", ready_seen & 4'b1011, 0);
    chk("t27_ch2_rdy", ready_seen[2], 1);

    // 1000 random packets, all channels, random back-pressure
    set_cfg(1, 16, 0, 0, 70);
    for (int k = 0; k < N_CH; k++) pkts_left[k] = 250;
    run("t28", 40000);
    chk("t28_pkts", n_pkts, 1000);

    // plus valid gaps and inter-packet idle
    set_cfg(1, 16, 25, 20, 70);
    for (int k = 0; k < N_CH; k++) pkts_left[k] = 250;
    run("t29", 50000);
    chk("t29_pkts", n_pkts, 1000);

    // reset in the middle of a ch1 packet, after moving the pointer to 2
    set_cfg(4, 4, 0, 0, 100);
    pkts_left[1] = 1;
    run("t30_pre", 100);
    pkts_left[1] = 1;
    w = 0;
    while (!(active[1] && beat[1] == 1) && w < 50) begin
      step();
      w++;
    end
    chk("t30_reach", (active[1] && beat[1] == 1), 1);
    chk("t30_pre_idx", idx_channel, 1);
    rst = 1'b1;
    #1;
    chk("t30_rst_valid", so.t_valid, 0);
    chk("t30_rst_ready", rdy, 0);
    chk("t30_rst_idx", idx_channel, 0);
    clear_tb();
    repeat (2) step();
    rst = 1'b0;
    set_cfg(4, 4, 0, 0, 100);
    for (int k = 0; k < N_CH; k++) pkts_left[k] = 1;
    run("t30_post", 200);
    chk("t30_npkt", idx_log.size(), 4);
    if (idx_log.size() > 0) chk("t30_first", idx_log[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
